// File: rtl/exdes_wqe_fetch_master.sv
// AXI4 read master for WQE fetches: issues one AR burst per request, tracks bursts in flight and
// streams R beats out through a single register stage, framing bursts by the issued ARLEN.
module exdes_wqe_fetch_master #(
    parameter int unsigned C_AXIS_DATA_WIDTH = 512,
    parameter int unsigned C_ADDR_WIDTH      = 64,
    parameter int unsigned C_MAX_OUTSTANDING = 4
) (
    input  logic                         core_clk,
    input  logic                         core_reset,

    input  logic                         fetch_req_valid,
    output logic                         fetch_req_ready,
    input  logic [C_ADDR_WIDTH-1:0]      fetch_req_addr,
    input  logic [7:0]                   fetch_req_len,

    output logic [C_ADDR_WIDTH-1:0]      wqe_proc_top_m_axi_araddr,
    output logic [7:0]                   wqe_proc_top_m_axi_arlen,
    output logic                         wqe_proc_top_m_axi_arvalid,
    input  logic                         wqe_proc_top_m_axi_arready,
    input  logic [C_AXIS_DATA_WIDTH-1:0] wqe_proc_top_m_axi_rdata,
    input  logic                         wqe_proc_top_m_axi_rlast,
    input  logic                         wqe_proc_top_m_axi_rvalid,
    output logic                         wqe_proc_top_m_axi_rready,

    output logic [C_AXIS_DATA_WIDTH-1:0] m_wqe_tdata,
    output logic                         m_wqe_tvalid,
    output logic                         m_wqe_tlast,
    input  logic                         m_wqe_tready,

    output logic [4:0]                   outstanding_cnt,
    output logic                         len_err,
    input  logic                         len_err_clr
);

    localparam int unsigned PtrW   = $clog2(C_MAX_OUTSTANDING);
    localparam logic [4:0]  MaxOut = 5'(C_MAX_OUTSTANDING);

    typedef enum logic {
        ArIdle,
        ArIssue
    } ar_state_e;

    ar_state_e        ar_state_q;
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [7:0]       len_mem [C_MAX_OUTSTANDING];
    logic [7:0]       beat_cnt_q;
    logic [7:0]       head_len;
    logic             fetch_fire;
    logic             r_fire;
    logic             fifo_empty;
    logic             exp_last;
    logic             burst_done;

    // The length FIFO holds exactly one entry per outstanding burst, so its
    // occupancy is outstanding_cnt itself.
    assign fifo_empty      = (outstanding_cnt == 5'd0);
    assign fetch_req_ready = (ar_state_q == ArIdle) && (outstanding_cnt < MaxOut);
    assign fetch_fire      = fetch_req_valid && fetch_req_ready;

    assign wqe_proc_top_m_axi_rready = (~m_wqe_tvalid | m_wqe_tready) & ~fifo_empty;
    assign r_fire     = wqe_proc_top_m_axi_rvalid & wqe_proc_top_m_axi_rready;
    assign head_len   = len_mem[rd_ptr_q];
    assign exp_last   = (beat_cnt_q == head_len);
    assign burst_done = r_fire & exp_last;

    // AR issue FSM: one request captured per visit to ArIdle.
    always_ff @(posedge core_clk) begin
        if (core_reset) begin
            ar_state_q                 <= ArIdle;
            wqe_proc_top_m_axi_araddr  <= '0;
            wqe_proc_top_m_axi_arlen   <= '0;
            wqe_proc_top_m_axi_arvalid <= 1'b0;
        end else begin
            unique case (ar_state_q)
                ArIdle: begin
                    if (fetch_fire) begin
                        wqe_proc_top_m_axi_araddr  <= fetch_req_addr;
                        wqe_proc_top_m_axi_arlen   <= fetch_req_len;
                        wqe_proc_top_m_axi_arvalid <= 1'b1;
                        ar_state_q                 <= ArIssue;
                    end
                end
                ArIssue: begin
                    if (wqe_proc_top_m_axi_arready) begin
                        wqe_proc_top_m_axi_arvalid <= 1'b0;
                        ar_state_q                 <= ArIdle;
                    end
                end
                default: ar_state_q <= ArIdle;
            endcase
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_reset) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            outstanding_cnt <= 5'd0;
        end else begin
            if (fetch_fire) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (burst_done) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({fetch_fire, burst_done})
                2'b10:   outstanding_cnt <= outstanding_cnt + 5'd1;
                2'b01:   outstanding_cnt <= outstanding_cnt - 5'd1;
                default: outstanding_cnt <= outstanding_cnt;
            endcase
        end
    end

    // Storage only; validity is tracked by the pointers and outstanding_cnt.
    always_ff @(posedge core_clk) begin
        if (fetch_fire) begin
            len_mem[wr_ptr_q] <= fetch_req_len;
        end
    end

    // R capture stage. Framing follows the expected beat count, never rlast.
    always_ff @(posedge core_clk) begin
        if (core_reset) begin
            m_wqe_tdata  <= '0;
            m_wqe_tvalid <= 1'b0;
            m_wqe_tlast  <= 1'b0;
            beat_cnt_q   <= 8'd0;
            len_err      <= 1'b0;
        end else begin
            if (r_fire) begin
                m_wqe_tdata  <= wqe_proc_top_m_axi_rdata;
                m_wqe_tvalid <= 1'b1;
                m_wqe_tlast  <= exp_last;
                beat_cnt_q   <= exp_last ? 8'd0 : beat_cnt_q + 8'd1;
            end else if (m_wqe_tready) begin
                m_wqe_tvalid <= 1'b0;
                m_wqe_tlast  <= 1'b0;
            end

            if (r_fire && (wqe_proc_top_m_axi_rlast != exp_last)) begin
                len_err <= 1'b1;
            end else if (len_err_clr) begin
                len_err <= 1'b0;
            end
        end
    end

endmodule
